// File: rtl/vram_arbiter.sv
// Single-port framebuffer arbiter: 4x4-upscaled VGA scanout has absolute priority,
// leftover cycles are shared round-robin between draw-engine writes and host reads.
module vram_arbiter #(
  parameter int FB_W = 160,
  parameter int FB_H = 120
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  input  logic        pix_en,
  input  logic        pix_hs,
  input  logic        pix_vs,
  output logic [11:0] rgb,
  output logic        hsync,
  output logic        vsync,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [7:0]  wr_x,
  input  logic [6:0]  wr_y,
  input  logic [11:0] wr_data,
  input  logic        rd_valid,
  output logic        rd_ready,
  input  logic [7:0]  rd_x,
  input  logic [6:0]  rd_y,
  output logic        rd_rvalid,
  output logic [11:0] rd_rdata,
  output logic        oob_err,
  output logic [14:0] ram_addr,
  output logic        ram_we,
  output logic [11:0] ram_wdata,
  input  logic [11:0] ram_rdata
);
  localparam logic [7:0] FB_W8 = 8'(FB_W);
  localparam logic [6:0] FB_H7 = 7'(FB_H);

  function automatic logic [14:0] xy_addr(input logic [6:0] y, input logic [7:0] x);
    return (15'(y) << 7) + (15'(y) << 5) + 15'(x);
  endfunction

  logic        disp_slot, wr_oob, rd_oob, wr_hs, rd_hs;
  logic [14:0] addr_d, addr_q;
  logic        last_gnt_q;
  logic        rd_pend_q, rd_pend_oob_q, rd_rvalid_q, oob_q;
  logic [11:0] rd_rdata_q, pix_q, rgb_q;
  logic        disp_d1_q;
  logic [1:0]  en_pipe_q, hs_pipe_q, vs_pipe_q;

  // Only rows 0..479 reach this block, so pix_y[8:2] covers the stored row.
  logic unused_pix_y;
  assign unused_pix_y = ^{pix_y[9], pix_y[1:0]};

  always_comb begin
    disp_slot = pix_en && (pix_x[1:0] == 2'b00);
    wr_oob    = (wr_x >= FB_W8) || (wr_y >= FB_H7);
    rd_oob    = (rd_x >= FB_W8) || (rd_y >= FB_H7);
    // last_gnt_q=1 means the read went last, so the write wins a tie.
    wr_ready  = !disp_slot && wr_valid && (!rd_valid || last_gnt_q);
    rd_ready  = !disp_slot && rd_valid && (!wr_valid || !last_gnt_q);
    wr_hs     = wr_valid && wr_ready;
    rd_hs     = rd_valid && rd_ready;
    ram_we    = wr_hs && !wr_oob;
    ram_wdata = wr_data;
    addr_d    = addr_q;
    if (disp_slot)             addr_d = xy_addr(pix_y[8:2], pix_x[9:2]);
    else if (wr_hs && !wr_oob) addr_d = xy_addr(wr_y, wr_x);
    else if (rd_hs && !rd_oob) addr_d = xy_addr(rd_y, rd_x);
    ram_addr  = addr_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q        <= '0;
      last_gnt_q    <= 1'b1;
      rd_pend_q     <= 1'b0;
      rd_pend_oob_q <= 1'b0;
      rd_rvalid_q   <= 1'b0;
      rd_rdata_q    <= '0;
      oob_q         <= 1'b0;
      disp_d1_q     <= 1'b0;
      pix_q         <= '0;
      rgb_q         <= '0;
      en_pipe_q     <= '0;
      hs_pipe_q     <= '0;
      vs_pipe_q     <= '0;
    end else begin
      addr_q <= addr_d;
      if (wr_hs)      last_gnt_q <= 1'b0;
      else if (rd_hs) last_gnt_q <= 1'b1;
      rd_pend_q     <= rd_hs;
      rd_pend_oob_q <= rd_hs && rd_oob;
      rd_rvalid_q   <= rd_pend_q;
      if (rd_pend_q) rd_rdata_q <= rd_pend_oob_q ? 12'h000 : ram_rdata;
      oob_q     <= (wr_hs && wr_oob) || (rd_hs && rd_oob);
      disp_d1_q <= disp_slot;
      if (disp_d1_q) pix_q <= ram_rdata;
      // Take RAM data straight through on reload so rgb lands two cycles after the slot.
      rgb_q     <= en_pipe_q[0] ? (disp_d1_q ? ram_rdata : pix_q) : 12'h000;
      en_pipe_q <= {en_pipe_q[0], pix_en};
      hs_pipe_q <= {hs_pipe_q[0], pix_hs};
      vs_pipe_q <= {vs_pipe_q[0], pix_vs};
    end
  end

  assign rgb       = rgb_q;
  assign hsync     = hs_pipe_q[1];
  assign vsync     = vs_pipe_q[1];
  assign rd_rvalid = rd_rvalid_q;
  assign rd_rdata  = rd_rdata_q;
  assign oob_err   = oob_q;
endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a registered 160x120 RAM model and shadow framebuffer.
module tb_vram_arbiter;
  logic        clk, rst;
  logic [9:0]  pix_x, pix_y;
  logic        pix_en, pix_hs, pix_vs;
  logic [11:0] rgb;
  logic        hsync, vsync;
  logic        wr_valid, wr_ready;
  logic [7:0]  wr_x;
  logic [6:0]  wr_y;
  logic [11:0] wr_data;
  logic        rd_valid, rd_ready;
  logic [7:0]  rd_x;
  logic [6:0]  rd_y;
  logic        rd_rvalid;
  logic [11:0] rd_rdata;
  logic        oob_err;
  logic [14:0] ram_addr;
  logic        ram_we;
  logic [11:0] ram_wdata, ram_rdata;

  logic [11:0] mem    [0:19199];
  logic [11:0] shadow [0:19199];
  int vec, errs;

  logic [9:0] p1_x, p2_x, p1_y, p2_y;
  logic       p1_en, p2_en, p1_hs, p2_hs, p1_vs, p2_vs;

  vram_arbiter #(.FB_W(160), .FB_H(120)) dut (
    .clk(clk), .rst(rst), .pix_x(pix_x), .pix_y(pix_y), .pix_en(pix_en),
    .pix_hs(pix_hs), .pix_vs(pix_vs), .rgb(rgb), .hsync(hsync), .vsync(vsync),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_x(rd_x), .rd_y(rd_y),
    .rd_rvalid(rd_rvalid), .rd_rdata(rd_rdata), .oob_err(oob_err),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we && ram_addr < 15'd19200) mem[ram_addr] <= ram_wdata;
    ram_rdata <= (ram_addr < 15'd19200) ? mem[ram_addr] : 12'h000;
  end

  // Input history: after an edge, p2_* holds what was driven two cycles earlier.
  always @(posedge clk) begin
    p2_x <= p1_x; p2_y <= p1_y; p2_en <= p1_en; p2_hs <= p1_hs; p2_vs <= p1_vs;
    p1_x <= pix_x; p1_y <= pix_y; p1_en <= pix_en; p1_hs <= pix_hs; p1_vs <= pix_vs;
  end

  task automatic cyc;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1; pix_en = 1; pix_x = 0; pix_y = 0; pix_hs = 1; pix_vs = 1;
    repeat (3) cyc;
    vec += 6;
    if (rgb !== 12'h000)   begin errs++; $display("FAIL reset_rgb got %h exp 000", rgb); end
    if (hsync !== 1'b0)    begin errs++; $display("FAIL reset_hsync got %b exp 0", hsync); end
    if (vsync !== 1'b0)    begin errs++; $display("FAIL reset_vsync got %b exp 0", vsync); end
    if (rd_rvalid !== 1'b0) begin errs++; $display("FAIL reset_rvalid got %b exp 0", rd_rvalid); end
    if (rd_rdata !== 12'h000) begin errs++; $display("FAIL reset_rdata got %h exp 000", rd_rdata); end
    if (oob_err !== 1'b0)  begin errs++; $display("FAIL reset_oob got %b exp 0", oob_err); end
    rst = 0;
    cyc;
    vec += 2;
    if (hsync !== 1'b0) begin errs++; $display("FAIL release_hsync got %b exp 0", hsync); end
    if (rgb !== 12'h000) begin errs++; $display("FAIL release_rgb got %h exp 000", rgb); end
    cyc;
    vec += 2;
    if (hsync !== 1'b1) begin errs++; $display("FAIL release_hsync2 got %b exp 1", hsync); end
    if (vsync !== 1'b1) begin errs++; $display("FAIL release_vsync2 got %b exp 1", vsync); end
    pix_en = 0; pix_hs = 0; pix_vs = 0;
    repeat (3) cyc;
  endtask

  // One line: 640 active columns (rows >= 480 are blank), then a blank tail with an hsync pulse.
  task automatic test_scanout_line(input int py, input logic vs);
    logic [11:0] exp_rgb;
    int idx;
    for (int t = 0; t < 656; t++) begin
      pix_en = (t < 640) && (py < 480);
      pix_x  = (t < 640) ? 10'(t) : 10'd0;
      pix_y  = 10'(py);
      pix_hs = (t >= 644) && (t < 650);
      pix_vs = vs;
      cyc;
      idx = (int'(p2_y) >> 2) * 160 + (int'(p2_x) >> 2);
      exp_rgb = p2_en ? shadow[idx] : 12'h000;
      vec += 2;
      if (rgb !== exp_rgb) begin
        errs++; $display("FAIL scan_rgb py=%0d t=%0d got %h exp %h", py, t, rgb, exp_rgb);
      end
      if ({hsync, vsync} !== {p2_hs, p2_vs}) begin
        errs++; $display("FAIL scan_sync py=%0d t=%0d got %b%b exp %b%b", py, t, hsync, vsync, p2_hs, p2_vs);
      end
    end
    pix_en = 0; pix_hs = 0; pix_vs = 0;
  endtask

  task automatic test_frame;
    test_scanout_line(0, 1'b0);
    test_scanout_line(3, 1'b0);
    test_scanout_line(4, 1'b0);
    test_scanout_line(479, 1'b0);
    test_scanout_line(500, 1'b1);
  endtask

  task automatic test_write_read;
    wr_valid = 1; wr_x = 10; wr_y = 5; wr_data = 12'hABC;
    #1;
    vec += 4;
    if (wr_ready !== 1'b1) begin errs++; $display("FAIL wr_ready got %b exp 1", wr_ready); end
    if (ram_we !== 1'b1) begin errs++; $display("FAIL wr_we got %b exp 1", ram_we); end
    if (ram_addr !== 15'd810) begin errs++; $display("FAIL wr_addr got %0d exp 810", ram_addr); end
    if (ram_wdata !== 12'hABC) begin errs++; $display("FAIL wr_wdata got %h exp abc", ram_wdata); end
    cyc;
    shadow[810] = 12'hABC;
    wr_valid = 0; rd_valid = 1; rd_x = 10; rd_y = 5;
    #1;
    vec += 3;
    if (rd_ready !== 1'b1) begin errs++; $display("FAIL rd_ready got %b exp 1", rd_ready); end
    if (ram_addr !== 15'd810) begin errs++; $display("FAIL rd_addr got %0d exp 810", ram_addr); end
    if (ram_we !== 1'b0) begin errs++; $display("FAIL rd_we got %b exp 0", ram_we); end
    cyc;
    rd_valid = 0;
    vec++;
    if (rd_rvalid !== 1'b0) begin errs++; $display("FAIL rd_early got %b exp 0", rd_rvalid); end
    cyc;
    vec += 2;
    if (rd_rvalid !== 1'b1) begin errs++; $display("FAIL rd_rvalid got %b exp 1", rd_rvalid); end
    if (rd_rdata !== 12'hABC) begin errs++; $display("FAIL rd_rdata got %h exp abc", rd_rdata); end
    cyc;
    vec++;
    if (rd_rvalid !== 1'b0) begin errs++; $display("FAIL rd_pulse_len got %b exp 1-cycle", rd_rvalid); end
  endtask

  task automatic test_contention;
    logic lg, exp_w;
    rst = 1; cyc; rst = 0; cyc;
    lg = 1'b1;
    wr_valid = 1; wr_x = 0; wr_y = 119; wr_data = shadow[19040];
    rd_valid = 1; rd_x = 1; rd_y = 0;
    for (int t = 0; t < 24; t++) begin
      pix_en = 1; pix_x = 10'(t); pix_y = 10'd8;
      #1;
      if (t % 4 == 0) begin
        vec += 2;
        if ({wr_ready, rd_ready, ram_we} !== 3'b000) begin
          errs++; $display("FAIL slot_ready t=%0d got w%b r%b we%b exp 000", t, wr_ready, rd_ready, ram_we);
        end
        if (ram_addr !== 15'(320 + t / 4)) begin
          errs++; $display("FAIL slot_addr t=%0d got %0d exp %0d", t, ram_addr, 320 + t / 4);
        end
      end else begin
        exp_w = lg;
        vec++;
        if ({wr_ready, rd_ready, ram_we} !== {exp_w, !exp_w, exp_w}) begin
          errs++; $display("FAIL rr_grant t=%0d got w%b r%b we%b exp w%b r%b we%b",
                           t, wr_ready, rd_ready, ram_we, exp_w, !exp_w, exp_w);
        end
        lg = !exp_w;
      end
      cyc;
    end
    wr_valid = 0; rd_valid = 0; pix_en = 0;
    repeat (4) cyc;
  endtask

  task automatic test_oob;
    rd_valid = 1; rd_x = 5; rd_y = 0;
    #1;
    vec++;
    if (rd_ready !== 1'b1) begin errs++; $display("FAIL oob_pre_rd got %b exp 1", rd_ready); end
    cyc;
    rd_valid = 0; wr_valid = 1; wr_x = 160; wr_y = 0; wr_data = 12'h123;
    #1;
    vec += 2;
    if (wr_ready !== 1'b1) begin errs++; $display("FAIL oob_wr_ready got %b exp 1", wr_ready); end
    if (ram_we !== 1'b0) begin errs++; $display("FAIL oob_wr_we got %b exp 0", ram_we); end
    cyc;
    wr_valid = 0;
    vec += 3;
    if (rd_rvalid !== 1'b1) begin errs++; $display("FAIL oob_pre_rvalid got %b exp 1", rd_rvalid); end
    if (rd_rdata !== 12'h005) begin errs++; $display("FAIL oob_pre_rdata got %h exp 005", rd_rdata); end
    if (oob_err !== 1'b1) begin errs++; $display("FAIL oob_wr_err got %b exp 1", oob_err); end
    cyc;
    vec++;
    if (oob_err !== 1'b0) begin errs++; $display("FAIL oob_wr_err_len got %b exp 0", oob_err); end
    rd_valid = 1; rd_x = 0; rd_y = 120;
    #1;
    vec += 2;
    if (rd_ready !== 1'b1) begin errs++; $display("FAIL oob_rd_ready got %b exp 1", rd_ready); end
    if (ram_we !== 1'b0) begin errs++; $display("FAIL oob_rd_we got %b exp 0", ram_we); end
    cyc;
    rd_valid = 0;
    vec += 2;
    if (oob_err !== 1'b1) begin errs++; $display("FAIL oob_rd_err got %b exp 1", oob_err); end
    if (rd_rvalid !== 1'b0) begin errs++; $display("FAIL oob_rd_early got %b exp 0", rd_rvalid); end
    cyc;
    vec += 3;
    if (rd_rvalid !== 1'b1) begin errs++; $display("FAIL oob_rd_rvalid got %b exp 1", rd_rvalid); end
    if (rd_rdata !== 12'h000) begin errs++; $display("FAIL oob_rd_rdata got %h exp 000", rd_rdata); end
    if (oob_err !== 1'b0) begin errs++; $display("FAIL oob_rd_err_len got %b exp 0", oob_err); end
    cyc;
  endtask

  task automatic test_reset_mid;
    rd_valid = 1; rd_x = 2; rd_y = 0;
    #1;
    vec++;
    if (rd_ready !== 1'b1) begin errs++; $display("FAIL mid_rd_ready got %b exp 1", rd_ready); end
    cyc;
    rd_valid = 0; rst = 1; wr_valid = 1; wr_x = 3; wr_y = 0; wr_data = 12'h5A5;
    #1;
    vec++;
    if ({wr_ready, ram_we} !== 2'b11) begin errs++; $display("FAIL mid_wr got %b%b exp 11", wr_ready, ram_we); end
    cyc;
    shadow[3] = 12'h5A5;
    vec++;
    if ({rd_rvalid, rd_rdata, oob_err, rgb, hsync, vsync} !== 28'd0) begin
      errs++; $display("FAIL mid_outputs got rv%b rd%h oob%b rgb%h hs%b vs%b exp all 0",
                       rd_rvalid, rd_rdata, oob_err, rgb, hsync, vsync);
    end
    rst = 0; wr_valid = 0;
    cyc;
    vec++;
    if (rd_rvalid !== 1'b0) begin errs++; $display("FAIL mid_rvalid got %b exp 0", rd_rvalid); end
    wr_valid = 1; rd_valid = 1; rd_x = 3; rd_y = 0;
    #1;
    vec++;
    if ({wr_ready, rd_ready} !== 2'b10) begin errs++; $display("FAIL mid_lastgnt got w%b r%b exp w1 r0", wr_ready, rd_ready); end
    cyc;
    wr_valid = 0;
    #1;
    vec++;
    if (rd_ready !== 1'b1) begin errs++; $display("FAIL mid_rd2_ready got %b exp 1", rd_ready); end
    cyc;
    rd_valid = 0;
    cyc;
    vec++;
    if ({rd_rvalid, rd_rdata} !== {1'b1, 12'h5A5}) begin
      errs++; $display("FAIL mid_rd2_data got rv%b %h exp rv1 5a5", rd_rvalid, rd_rdata);
    end
    cyc;
  endtask

  task automatic test_tearing;
    test_scanout_line(0, 1'b0);
    wr_valid = 1; wr_x = 2; wr_y = 1; wr_data = 12'hF0F;
    #1;
    vec++;
    if ({wr_ready, ram_we, ram_addr} !== {2'b11, 15'd162}) begin
      errs++; $display("FAIL tear_wr got rdy%b we%b addr%0d exp 1 1 162", wr_ready, ram_we, ram_addr);
    end
    cyc;
    wr_valid = 0;
    shadow[162] = 12'hF0F;
    for (int py = 4; py < 8; py++) test_scanout_line(py, 1'b0);
  endtask

  initial begin
    clk = 0; rst = 1; vec = 0; errs = 0;
    pix_x = 0; pix_y = 0; pix_en = 0; pix_hs = 0; pix_vs = 0;
    wr_valid = 0; wr_x = 0; wr_y = 0; wr_data = 0;
    rd_valid = 0; rd_x = 0; rd_y = 0;
    for (int i = 0; i < 19200; i++) begin
      mem[i] = 12'(i);
      shadow[i] = 12'(i);
    end
    test_reset;
    test_frame;
    test_write_read;
    test_contention;
    test_oob;
    test_reset_mid;
    test_tearing;
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Shares one single-port 160x120x12-bit pixel RAM between VGA scanout and two requesters: the draw engine (writes) and the host (reads). Scanout has absolute priority and upscales each stored pixel 4x4 onto the 640x480 active area. The block sits between the 640x480@60 timing generator and the RGB/sync output pins. It also delays sync and blank by the RAM latency so the pixel data stays aligned.

## Interface
Parameters:
- FB_W, 160, framebuffer width in stored pixels
- FB_H, 120, framebuffer height in stored pixels

Ports:
- clk  in  1  pixel clock (25 MHz)
- rst  in  1  synchronous, active-high reset
- pix_x  in  10  active-area column from the timing generator (0..639 when pix_en)
- pix_y  in  10  active-area row (0..479 when pix_en)
- pix_en  in  1  active-video flag
- pix_hs, pix_vs  in  1 each  syncs from the timing generator
- rgb  out  12  pixel to DAC
- hsync, vsync  out  1 each  syncs delayed 2 cycles
- wr_valid  in  1  draw-engine write request
- wr_ready  out  1  write granted this cycle
- wr_x  in  8  target column
- wr_y  in  7  target row
- wr_data  in  12  pixel value
- rd_valid  in  1  host read request
- rd_ready  out  1  read granted this cycle
- rd_x  in  8  source column
- rd_y  in  7  source row
- rd_rvalid  out  1  one-cycle pulse when read data is valid
- rd_rdata  out  12  read data
- oob_err  out  1  one-cycle pulse after an out-of-range access is accepted
- ram_addr  out  15  RAM address, combinational
- ram_we  out  1  RAM write enable, combinational
- ram_wdata  out  12  RAM write data
- ram_rdata  in  12  RAM read data, valid the cycle after the address (registered RAM)

## Operation
- Address: addr = y*160 + x, computed as (y<<7)+(y<<5)+x at 15 bits with no overflow (maximum 19199).
- Display slot: a cycle where pix_en && pix_x[1:0]==0.
  - ram_addr = (pix_y>>2)*160 + (pix_x>>2); ram_we=0.
  - wr_ready=0 and rd_ready=0.
- Free slot: every other cycle. The arbiter grants at most one requester:
  - Only one valid: that requester gets ready=1.
  - Both valid: round-robin on register last_gnt (0=write, 1=read). The requester not granted last time wins.
  - last_gnt updates only on a completed handshake (valid&&ready).
- Handshake: a transfer occurs when valid&&ready in the same cycle. Requesters hold valid and payload stable until ready. Ready is combinational from the slot, valid, and last_gnt, and does not depend on ready.
- Granted write:
  - In range (x<160, y<120): ram_addr from wr_x/wr_y, ram_we=1, ram_wdata=wr_data.
  - Out of range: ram_we=0 and the write is dropped, still completes, and oob_err=1 the next cycle.
- Granted read:
  - In range: ram_addr from rd_x/rd_y, ram_we=0. The next cycle, rd_rdata<=ram_rdata at that cycle's end, and rd_rvalid=1 for the cycle after that.
  - Out of range: the RAM is not read, rd_rdata=12'h000, rd_rvalid still pulses with normal latency, and oob_err pulses.
- Idle cycles (no slot use): ram_we=0; ram_addr holds its previous value (don't-care to the verifier).
- Scanout pipeline:
  - pix_reg loads ram_rdata at the end of the cycle after each display slot.
  - pix_en, pix_hs and pix_vs are delayed by two registers.
  - rgb = delayed_en ? pix_reg : 12'h000, registered.

## Timing
- Reset values (all held while rst=1 and valid on the first cycle after release): rgb=0, hsync=0, vsync=0, rd_rvalid=0, rd_rdata=0, oob_err=0, pix_reg=0, delay pipes=0, last_gnt=1 (write wins the first contention).
- Display latency:
  - A slot issued in cycle T drives stored pixel (x>>2) on rgb in cycles T+2..T+5.
  - The next slot at T+4 reloads pix_reg at the end of T+5, so output is contiguous.
  - hsync, vsync and blanking lag the inputs by exactly 2 cycles.
- Read latency: grant in cycle T gives rd_rvalid=1 in T+2 only.
  - Back-to-back grants give back-to-back rd_rvalid pulses.
- Write latency: the RAM is updated at the end of the grant cycle. A read granted at T+1 to the same address returns the new data.
- Bandwidth:
  - During active video, 3 of every 4 cycles are free.
  - During blanking, every cycle is free.
  - Under continuous contention, writes and reads alternate within free slots.
- rst asserted mid-transaction: in-flight read responses are discarded (rd_rvalid stays 0) and outputs return to reset values on the next edge. A write granted in the same cycle as rst is still presented to the RAM combinationally; the RAM model honours it.

## Test plan
- Reset, then a full frame with the RAM preloaded to addr[11:0] -> rgb at active pixel (px,py) equals ((py>>2)*160+(px>>2))[11:0] two cycles after input; blanking rgb=0; hsync/vsync equal inputs delayed 2.
- Write (10,5)=12'hABC during blanking, then host read (10,5) -> ram_we pulse at addr 810; rd_rvalid 2 cycles after read grant with rd_rdata=12'hABC.
- wr_valid and rd_valid held continuously through an active line -> no ready in display slots; grants alternate W,R,W,R starting with W after reset; no RAM access in display slots.
- Write (160,0) and read (0,120) -> both accepted; no ram_we; oob_err pulses once each; read returns 12'h000 with normal latency.
- rst raised the cycle after a read grant -> no rd_rvalid; all outputs 0; last_gnt=1.
- Write a framebuffer pixel mid-frame ahead of scanout -> that 4x4 block shows the new colour in the same frame with no tearing of neighbouring blocks.
